// File: rtl/counter_counter_if.sv
// Load/enable/data bundle and registered count output of the modulo counter.
interface counter_counter_if #(
  parameter int WIDTH = 4
) ();
  logic [WIDTH-1:0] d;
  logic             load;
  logic             enable;
  logic [WIDTH-1:0] q;

  modport master (output d, output load, output enable, input q);
  modport slave  (input d, input load, input enable, output q);
endinterface

// File: rtl/counter_counter.sv
// Modulo up-counter 0..MAX with saturating parallel load; load > enable > hold.
module counter_counter #(
  parameter int unsigned MAX   = 12,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  counter_counter_if.slave bus
);

  if (MAX < 1 || longint'(MAX) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("counter_counter: MAX must satisfy 1 <= MAX <= 2**WIDTH-1");
  end

  if ($bits(bus.q) != WIDTH) begin : g_bad_width
    $error("counter_counter: interface WIDTH does not match module WIDTH");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;

  // Out-of-range load values clamp to MAX so q never leaves 0..MAX.
  always_comb begin
    count_nxt = count;
    if (bus.load) begin
      count_nxt = (bus.d > MAXV) ? MAXV : bus.d;
    end else if (bus.enable) begin
      count_nxt = (count == MAXV) ? '0 : count + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  assign bus.q = count;

endmodule

// File: tb/tb_counter_counter.sv
// Directed bench: MAX=12 instance plus a full-range MAX=15 variant.
module tb_counter_counter;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_fails;

  counter_counter_if #(.WIDTH(4)) bus12 ();
  counter_counter_if #(.WIDTH(4)) bus15 ();

  counter_counter #(.MAX(12), .WIDTH(4)) dut12 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus12.slave)
  );

  counter_counter #(.MAX(15), .WIDTH(4)) dut15 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus15.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; sample 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [3:0] dseq [4];
    n_checks = 0;
    n_fails  = 0;
    dseq[0] = 4'd3; dseq[1] = 4'd12; dseq[2] = 4'd0; dseq[3] = 4'd9;

    reset_n      = 1'b0;
    bus12.enable = 1'b1;
    bus12.load   = 1'b1;
    bus12.d      = 4'd5;
    bus15.enable = 1'b0;
    bus15.load   = 1'b0;
    bus15.d      = 4'd0;

    // Reset held with load/enable active
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_hold", bus12.q, 4'd0);
    end
    check("reset_hold15", bus15.q, 4'd0);
    bus12.enable = 1'b0;
    bus12.load   = 1'b0;
    reset_n      = 1'b1;
    step();
    check("reset_release_idle", bus12.q, 4'd0);

    // Count and wrap: 1..12, 0, 1, 2, 3
    bus12.enable = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("count_%0d", i), bus12.q, 4'(i % 13));
    end
    bus12.enable = 1'b0;
    step();
    check("hold_a", bus12.q, 4'd3);
    step();
    check("hold_b", bus12.q, 4'd3);

    // Load with enable low, then tracking d
    bus12.load = 1'b1;
    bus12.d    = 4'd7;
    step();
    check("load_7", bus12.q, 4'd7);
    for (int i = 0; i < 4; i++) begin
      bus12.d = dseq[i];
      step();
      check($sformatf("load_track_%0d", i), bus12.q, dseq[i]);
    end
    bus12.enable = 1'b1;
    bus12.d      = 4'd4;
    step();
    check("load_over_enable_4", bus12.q, 4'd4);
    bus12.d = 4'd11;
    step();
    check("load_over_enable_11", bus12.q, 4'd11);

    // Saturating load
    bus12.d = 4'd15;
    step();
    check("sat_load_15", bus12.q, 4'd12);
    bus12.d = 4'd13;
    step();
    check("sat_load_13", bus12.q, 4'd12);
    bus12.load = 1'b0;
    step();
    check("wrap_after_sat", bus12.q, 4'd0);

    // Asynchronous reset mid-count
    bus12.load = 1'b1;
    bus12.d    = 4'd8;
    step();
    check("preload_8", bus12.q, 4'd8);
    bus12.load = 1'b0;
    step();
    check("count_to_9", bus12.q, 4'd9);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_immediate", bus12.q, 4'd0);
    step();
    check("async_reset_held", bus12.q, 4'd0);
    reset_n = 1'b1;
    step();
    check("first_count_after_release", bus12.q, 4'd1);
    bus12.enable = 1'b0;

    // MAX=15 variant: full binary wrap
    bus15.enable = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      check($sformatf("v15_count_%0d", i), bus15.q, 4'(i % 16));
    end
    bus15.enable = 1'b0;
    bus15.load   = 1'b1;
    bus15.d      = 4'd15;
    step();
    check("v15_load_15", bus15.q, 4'd15);
    bus15.load   = 1'b0;
    bus15.enable = 1'b1;
    step();
    check("v15_wrap_from_load", bus15.q, 4'd0);
    check("idle12_unchanged", bus12.q, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
